dmem_copy_engine: RTL and testbench

- Bus initiator that drives the data memory's port (byte address, write data, write enable, combinational read data) to copy a block of 32-bit words from one region of the 256-byte memory to another.
- Sits beside the single-cycle core; the top level muxes its mem_* outputs onto the memory port while busy is high.
- Word-at-a-time, big-endian, no internal storage beyond one word buffer.

---
 rtl/dmem_copy_if.sv | 29 ++
 rtl/dmem_copy_engine.sv | 111 +++++++++++
 tb/tb_dmem_copy_engine.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_copy_if.sv
// Request/status and data-memory port bundle for the copy engine.
// The engine drives the memory port as master; the memory/control side is slave.
interface dmem_copy_if #(
    parameter int LEN_W = 7
);
    logic             start;
    logic [7:0]       src;
    logic [7:0]       dst;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] count;
    logic [31:0]      mem_a;
    logic [31:0]      mem_wd;
    logic             mem_we;
    logic [31:0]      mem_rd;

    modport master (
        input  start, src, dst, len, abort, mem_rd,
        output busy, done, err, count, mem_a, mem_wd, mem_we
    );

    modport slave (
        output start, src, dst, len, abort, mem_rd,
        input  busy, done, err, count, mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/dmem_copy_engine.sv
// Word-at-a-time block copier for the 256-byte data memory.
// Reads one big-endian word into a single buffer, writes it back, repeats.
module dmem_copy_engine #(
    parameter int MEM_BYTES = 256,
    parameter int LEN_W     = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_copy_if.master  bus
);
    typedef enum logic [2:0] {IDLE, CHECK, READ, WRITE, FIN} state_t;

    state_t           state, state_n;
    logic [7:0]       sptr, dptr;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      wbuf;
    logic             err_q;

    // End addresses are formed in 10 bits so a 64-word copy from a high
    // address cannot alias back into range.
    logic [9:0] s_end, d_end;
    logic       oob;
    assign s_end = 10'(sptr) + (10'(rem) << 2);
    assign d_end = 10'(dptr) + (10'(rem) << 2);
    assign oob   = (s_end > 10'(MEM_BYTES)) || (d_end > 10'(MEM_BYTES));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state: abort wins over everything once a copy is accepted.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (bus.start) state_n = CHECK;
            CHECK: begin
                if (bus.abort || oob || rem == '0) state_n = FIN;
                else                               state_n = READ;
            end
            READ:  state_n = bus.abort ? FIN : WRITE;
            WRITE: begin
                if (bus.abort || rem == LEN_W'(1)) state_n = FIN;
                else                               state_n = READ;
            end
            FIN:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: latch request, buffer the word, advance after each write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sptr  <= '0;
            dptr  <= '0;
            rem   <= '0;
            cnt   <= '0;
            wbuf  <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    sptr  <= bus.src;
                    dptr  <= bus.dst;
                    rem   <= bus.len;
                    cnt   <= '0;
                    err_q <= 1'b0;
                end
                CHECK: if (bus.abort || oob) err_q <= 1'b1;
                READ: begin
                    if (bus.abort) err_q <= 1'b1;
                    else           wbuf  <= bus.mem_rd;
                end
                WRITE: begin
                    // An aborted write still reaches memory but is not counted.
                    if (bus.abort) err_q <= 1'b1;
                    else begin
                        sptr <= sptr + 8'd4;
                        dptr <= dptr + 8'd4;
                        cnt  <= cnt + LEN_W'(1);
                        rem  <= rem - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory port and status are pure decodes of state so reset clears them at once.
    always_comb begin
        bus.mem_a  = 32'd0;
        bus.mem_wd = 32'd0;
        bus.mem_we = 1'b0;
        case (state)
            READ:  bus.mem_a = {24'd0, sptr};
            WRITE: begin
                bus.mem_a  = {24'd0, dptr};
                bus.mem_wd = wbuf;
                bus.mem_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy  = (state == READ) || (state == WRITE);
    assign bus.done  = (state == FIN);
    assign bus.err   = err_q;
    assign bus.count = cnt;
endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine with a byte-array memory model.
module tb_dmem_copy_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_copy_if #(.LEN_W(7)) bus ();
    dmem_copy_engine #(.MEM_BYTES(256), .LEN_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    int total = 0;
    int bad   = 0;
    logic [7:0] we_addr [16];
    int         we_cyc  [16];

    // Big-endian combinational read, write on the rising edge.
    assign bus.mem_rd = {mem[bus.mem_a[7:0]], mem[bus.mem_a[7:0] + 8'd1],
                         mem[bus.mem_a[7:0] + 8'd2], mem[bus.mem_a[7:0] + 8'd3]};
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_a[7:0]]        <= bus.mem_wd[31:24];
            mem[bus.mem_a[7:0] + 8'd1] <= bus.mem_wd[23:16];
            mem[bus.mem_a[7:0] + 8'd2] <= bus.mem_wd[15:8];
            mem[bus.mem_a[7:0] + 8'd3] <= bus.mem_wd[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdw(input logic [7:0] a);
        return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    endfunction

    // Pulse start, then watch cycle by cycle until done (cycle 1 = CHECK).
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [6:0] l,
                            input int restart_at, input int abort_at,
                            output int cyc, output int nbusy, output int nwe,
                            output logic [31:0] errv, output logic [31:0] cntv);
        @(negedge clk);
        bus.start = 1'b1; bus.src = s; bus.dst = d; bus.len = l;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1; nbusy = 0; nwe = 0;
        while (!bus.done && cyc < 400) begin
            if (bus.busy) nbusy++;
            if (bus.mem_we) begin
                if (nwe < 16) begin
                    we_addr[nwe] = bus.mem_a[7:0];
                    we_cyc[nwe]  = cyc;
                end
                nwe++;
            end
            if (cyc == restart_at) begin
                bus.start = 1'b1; bus.src = 8'h10; bus.dst = 8'hA0; bus.len = 7'd5;
            end else bus.start = 1'b0;
            bus.abort = (cyc == abort_at);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        errv = 32'(bus.err);
        cntv = 32'(bus.count);
    endtask

    initial begin
        int cyc, nb, nw;
        logic [31:0] e, c;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.src = '0; bus.dst = '0; bus.len = '0;
        for (int i = 0; i < 256; i++) mem[i] = (i < 64) ? 8'(i) : 8'h00;

        #12;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_we",   32'(bus.mem_we), 0);
        chk("rst_cnt",  32'(bus.count), 0);
        rst_n = 1'b1;

        // Aligned 4-word copy
        run_copy(8'h00, 8'h40, 7'd4, -1, -1, cyc, nb, nw, e, c);
        chk("t1_cyc",  32'(cyc), 10);
        chk("t1_busy", 32'(nb), 8);
        chk("t1_nwe",  32'(nw), 4);
        for (int k = 0; k < 4; k++) begin
            chk("t1_waddr", 32'(we_addr[k]), 32'h40 + 32'(4 * k));
            chk("t1_wcyc",  32'(we_cyc[k]),  32'(3 + 2 * k));
        end
        chk("t1_err", e, 0);
        chk("t1_cnt", c, 4);
        @(negedge clk);
        chk("t1_w44", rdw(8'h44), 32'h04050607);

        // Unaligned copy ending exactly at the top of memory
        run_copy(8'h01, 8'hF0, 7'd4, -1, -1, cyc, nb, nw, e, c);
        chk("t2_cyc", 32'(cyc), 10);
        chk("t2_err", e, 0);
        @(negedge clk);
        chk("t2_wF0", rdw(8'hF0), 32'h01020304);
        chk("t2_wFC", rdw(8'hFC), 32'h0D0E0F10);

        // Source range overruns memory by one byte
        run_copy(8'hF1, 8'h00, 7'd4, -1, -1, cyc, nb, nw, e, c);
        chk("t3_cyc", 32'(cyc), 2);
        chk("t3_nwe", 32'(nw), 0);
        chk("t3_err", e, 1);
        chk("t3_cnt", c, 0);

        // Zero length
        run_copy(8'h00, 8'h80, 7'd0, -1, -1, cyc, nb, nw, e, c);
        chk("t4_cyc",  32'(cyc), 2);
        chk("t4_busy", 32'(nb), 0);
        chk("t4_err",  e, 0);
        chk("t4_cnt",  c, 0);

        // Second start while busy is ignored
        run_copy(8'h00, 8'h80, 7'd3, 3, -1, cyc, nb, nw, e, c);
        chk("t5_cyc", 32'(cyc), 8);
        chk("t5_nwe", 32'(nw), 3);
        chk("t5_cnt", c, 3);
        chk("t5_err", e, 0);
        @(negedge clk);
        chk("t5_w88", rdw(8'h88), 32'h08090A0B);
        chk("t5_wA0", rdw(8'hA0), 32'h0);
        repeat (3) @(negedge clk);
        chk("t5_idle", 32'(bus.busy), 0);

        // Abort during the second write
        run_copy(8'h20, 8'hC0, 7'd4, -1, 5, cyc, nb, nw, e, c);
        chk("t6_cyc", 32'(cyc), 6);
        chk("t6_nwe", 32'(nw), 2);
        chk("t6_err", e, 1);
        chk("t6_cnt", c, 1);
        @(negedge clk);
        chk("t6_wC4", rdw(8'hC4), 32'h24252627);

        // Reset mid-copy, during the second write
        @(negedge clk);
        bus.start = 1'b1; bus.src = 8'h00; bus.dst = 8'hE0; bus.len = 7'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t7_pre_we",  32'(bus.mem_we), 1);
        chk("t7_pre_cnt", 32'(bus.count), 1);
        rst_n = 1'b0;
        #1;
        chk("t7_we",   32'(bus.mem_we), 0);
        chk("t7_busy", 32'(bus.busy), 0);
        chk("t7_cnt",  32'(bus.count), 0);
        chk("t7_a",    bus.mem_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
